// File: rtl/seq_pattern_gen_pkg.sv
// Shared types and constants for the serial pattern generator and its golden model.
package seqgen_pkg;
  localparam int DEF_W = 16;
  localparam int HIT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/seq_pattern_gen_if.sv
// Control/stream bundle between a pattern source driver (master) and seq_pattern_gen (slave).
interface seq_pattern_gen_if
  import seqgen_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int LENW = $clog2(W + 1)
);
  logic             start;
  logic [W-1:0]     pattern;
  logic [LENW-1:0]  len;
  logic             repeat_en;
  logic             stop;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic             exp_y;
  logic [HIT_W-1:0] hit_cnt;

  modport master (
    output start, pattern, len, repeat_en, stop,
    input  x, x_valid, busy, done, exp_y, hit_cnt
  );

  modport slave (
    input  start, pattern, len, repeat_en, stop,
    output x, x_valid, busy, done, exp_y, hit_cnt
  );
endinterface

// File: rtl/seq_run_tracker.sv
// Golden model of the overlapping 111/000 Mealy detector: two-bit history, exp_y, hit count.
module seq_run_tracker
  import seqgen_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             idle,
  input  logic             start_acc,
  input  logic             x,
  input  logic             x_valid,
  output logic             exp_y,
  output logic [HIT_W-1:0] hit_cnt
);
  logic       h1;
  logic       h2;
  logic [1:0] cnt;

  assign exp_y = x_valid && (cnt == 2'd2) && (x == h1) && (h1 == h2);

  // History survives repeat wraps so detections overlap across pass boundaries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h1      <= 1'b0;
      h2      <= 1'b0;
      cnt     <= 2'd0;
      hit_cnt <= '0;
    end else begin
      if (idle) begin
        h1  <= 1'b0;
        h2  <= 1'b0;
        cnt <= 2'd0;
      end else if (x_valid) begin
        h2 <= h1;
        h1 <= x;
        if (cnt != 2'd2) cnt <= cnt + 2'd1;
      end
      if (start_acc)  hit_cnt <= '0;
      else if (exp_y) hit_cnt <= sat_inc(hit_cnt);
    end
  end
endmodule

// File: rtl/seq_pattern_gen.sv
// Serial MSB-first pattern transmitter with repeat/abort; golden model under SEQGEN_EXPECT_EN.
module seq_pattern_gen
  import seqgen_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int LENW = $clog2(W + 1)
)(
  input logic              clk,
  input logic              rst,
  seq_pattern_gen_if.slave bus
);
  localparam int IDXW = (W > 1) ? $clog2(W) : 1;

  state_t          state, state_n;
  logic [IDXW-1:0] idx, idx_n;
  logic [W-1:0]    pat, pat_n;
  logic [LENW-1:0] len_q, len_n;
  logic [LENW-1:0] len_c;
  logic            x_q, x_valid_q, busy_q, done_q;

  assign len_c = (bus.len > LENW'(W)) ? LENW'(W) : bus.len;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    pat_n   = pat;
    len_n   = len_q;
    unique case (state)
      IDLE: begin
        if (bus.start && (bus.len != '0)) begin
          pat_n   = bus.pattern;
          len_n   = len_c;
          idx_n   = IDXW'(len_c - LENW'(1));
          state_n = SEND;
        end
      end
      SEND: begin
        if (bus.stop) begin
          state_n = DONE;
        end else if (idx == '0) begin
          if (bus.repeat_en) idx_n   = IDXW'(len_q - LENW'(1));
          else               state_n = DONE;
        end else begin
          idx_n = idx - IDXW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so x lines up with the bit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      pat       <= '0;
      len_q     <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      pat       <= pat_n;
      len_q     <= len_n;
      x_q       <= (state_n == SEND) ? pat_n[idx_n] : 1'b0;
      x_valid_q <= (state_n == SEND);
      busy_q    <= (state_n == SEND);
      done_q    <= (state_n == DONE);
    end
  end

  assign bus.x       = x_q;
  assign bus.x_valid = x_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

`ifdef SEQGEN_EXPECT_EN
  logic start_acc;
  assign start_acc = (state == IDLE) && bus.start && (bus.len != '0);

  seq_run_tracker u_tracker (
    .clk       (clk),
    .rst       (rst),
    .idle      (state == IDLE),
    .start_acc (start_acc),
    .x         (x_q),
    .x_valid   (x_valid_q),
    .exp_y     (bus.exp_y),
    .hit_cnt   (bus.hit_cnt)
  );
`else
  assign bus.exp_y   = 1'b0;
  assign bus.hit_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed self-checking bench for seq_pattern_gen; golden-model outputs expected only with SEQGEN_EXPECT_EN.
module tb_seq_pattern_gen;
  import seqgen_pkg::*;

`ifdef SEQGEN_EXPECT_EN
  localparam logic EXP = 1'b1;
`else
  localparam logic EXP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  seq_pattern_gen_if #(.W(16)) bus ();

  seq_pattern_gen #(.W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic xv, input logic yv);
    check({tag, ".x"},       bus.x,       xv);
    check({tag, ".x_valid"}, bus.x_valid, 1'b1);
    check({tag, ".busy"},    bus.busy,    1'b1);
    check({tag, ".done"},    bus.done,    1'b0);
    check({tag, ".exp_y"},   bus.exp_y,   yv & EXP);
  endtask

  task automatic chk_idle(input string tag, input logic dn, input int hits);
    check({tag, ".x"},       bus.x,       1'b0);
    check({tag, ".x_valid"}, bus.x_valid, 1'b0);
    check({tag, ".busy"},    bus.busy,    1'b0);
    check({tag, ".done"},    bus.done,    dn);
    check({tag, ".exp_y"},   bus.exp_y,   1'b0);
    check({tag, ".hit_cnt"}, bus.hit_cnt, EXP ? hits : 0);
  endtask

  task automatic start_pass(input logic [15:0] p, input logic [4:0] l, input logic rep);
    bus.pattern   = p;
    bus.len       = l;
    bus.repeat_en = rep;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  // Bits are 1-based; stream and ymask are MSB-aligned (bit 1 at position 15).
  task automatic run_bits(input string tag, input logic [15:0] stream, input logic [15:0] ymask,
                          input int from, input int to);
    for (int i = from; i <= to; i++) begin
      chk_bit($sformatf("%s.b%0d", tag, i), stream[16-i], ymask[16-i]);
      tick();
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.pattern = '0;
    bus.len = '0;
    bus.repeat_en = 1'b0;
    bus.stop = 1'b0;
    #12;
    chk_idle("reset", 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk_idle("post_reset", 1'b0, 0);

    // Full 16-bit pass.
    start_pass(16'b1000_1011_1011_1100, 5'd16, 1'b0);
    run_bits("t1", 16'b1000_1011_1011_1100, 16'b0001_0000_1000_1100, 1, 16);
    chk_idle("t1.done", 1'b1, 4);
    tick();
    chk_idle("t1.idle", 1'b0, 4);

    // Repeat two passes of 111 back-to-back.
    start_pass(16'h0007, 5'd3, 1'b1);
    check("t2.hit_clr", bus.hit_cnt, 0);
    run_bits("t2", 16'hFC00, 16'b0011_1100_0000_0000, 1, 4);
    bus.repeat_en = 1'b0;
    run_bits("t2", 16'hFC00, 16'b0011_1100_0000_0000, 5, 6);
    chk_idle("t2.done", 1'b1, 4);
    tick();
    chk_idle("t2.idle", 1'b0, 4);

    // Abort during bit 5.
    start_pass(16'b1000_1011_1011_1100, 5'd16, 1'b0);
    run_bits("t3", 16'b1000_1011_1011_1100, 16'b0001_0000_1000_1100, 1, 4);
    chk_bit("t3.b5", 1'b1, 1'b0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk_idle("t3.done", 1'b1, 1);
    tick();
    chk_idle("t3.idle", 1'b0, 1);

    // start while busy and start with len=0 are ignored.
    start_pass(16'h0005, 5'd3, 1'b0);
    chk_bit("t4.b1", 1'b1, 1'b0);
    bus.pattern = 16'hFFFF;
    bus.len = 5'd16;
    bus.start = 1'b1;
    tick();
    chk_bit("t4.b2", 1'b0, 1'b0);
    bus.start = 1'b0;
    tick();
    chk_bit("t4.b3", 1'b1, 1'b0);
    tick();
    chk_idle("t4.done", 1'b1, 0);
    bus.len = 5'd0;
    bus.start = 1'b1;
    tick();
    tick();
    chk_idle("t4.len0_a", 1'b0, 0);
    bus.start = 1'b0;
    tick();
    chk_idle("t4.len0_b", 1'b0, 0);

    // Asynchronous reset mid-SEND.
    start_pass(16'b1000_1011_1011_1100, 5'd16, 1'b0);
    run_bits("t5", 16'b1000_1011_1011_1100, 16'b0001_0000_1000_1100, 1, 6);
    check("t5.hit_pre", bus.hit_cnt, EXP ? 1 : 0);
    #2;
    rst = 1'b0;
    #1;
    chk_idle("t5.rst", 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk_idle("t5.rel", 1'b0, 0);
    start_pass(16'h0007, 5'd3, 1'b0);
    run_bits("t5r", 16'hE000, 16'b0010_0000_0000_0000, 1, 3);
    chk_idle("t5r.done", 1'b1, 1);
    tick();

    // len above W clamps to 16 bits.
    start_pass(16'hA5C3, 5'd20, 1'b0);
    run_bits("t6", 16'hA5C3, 16'b0000_0000_0100_1100, 1, 16);
    chk_idle("t6.done", 1'b1, 3);
    tick();
    chk_idle("t6.idle", 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial pattern transmitter feeding the 111/000 overlapping Mealy sequence detector. It latches a parallel pattern word and shifts it out one bit per clock on `x`, MSB-first, with a valid qualifier, optional continuous repeat and abort. An optional golden model emits the Mealy output the detector must produce for the same stream, so benches and self-checking top levels can compare `y` against `exp_y` cycle by cycle.

## Interface
- `W`, 16, maximum pattern length in bits
- `LENW`, `$clog2(W+1)`, width of `len`
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin transmission; sampled only in IDLE
- `pattern`  in  W  bits to send, bit `len-1` first, bit 0 last
- `len`  in  LENW  number of bits to send, 1..W
- `repeat_en`  in  1  at end of pass, restart from latched pattern
- `stop`  in  1  abort current transmission
- `x`  out  1  serial data bit (0 when not valid)
- `x_valid`  out  1  `x` carries a pattern bit this cycle
- `busy`  out  1  state is SEND
- `done`  out  1  one-cycle pulse on end or abort
- `exp_y`  out  1  expected detector output (SEQGEN_EXPECT_EN only)
- `hit_cnt`  out  8  expected detections since start, saturating (SEQGEN_EXPECT_EN only)

## Operation
- States: IDLE, SEND, DONE.
- IDLE: on edge with `start`=1 and `len`!=0, latch `pattern` and `len` (clamped to W if larger), load bit index = len-1, go SEND. `start` with `len`=0 is ignored; no `done`.
- SEND: `x` = latched `pattern[idx]`, `x_valid`=1, `busy`=1. Each edge decrements idx.
- Last bit (idx=0): next edge goes to one of the following.
  - If `repeat_en`=1 and `stop`=0, reload idx=len-1 with no gap cycle.
  - Otherwise go DONE.
- `stop`=1 on any SEND edge: go DONE; the current bit is the last one presented. `stop` has priority over `repeat_en`.
- DONE: `x`=0, `x_valid`=0, `busy`=0, `done`=1 for exactly one cycle; next edge goes IDLE.
- `start` outside IDLE is ignored; latched pattern and len are immutable until the next IDLE start.
- Reset (any time, async): state IDLE; `x`, `x_valid`, `busy`, `done`, `exp_y`, `hit_cnt` all 0; idx and latched pattern cleared.

## Timing
- `x`, `x_valid`, `busy`, `done` are registered outputs.
- Start latency: `start` sampled at edge N puts the first bit on `x` from edge N to N+1.
- One bit per cycle. A pass of L bits occupies L cycles. Repeated passes are back-to-back.
- `done` is asserted in the cycle after the last valid bit (or the aborted bit).
- Minimum turnaround: the earliest new `start` is sampled in IDLE, 2 edges after the last bit.
- `exp_y` is combinational from the registered `x` and history, valid in the same cycle as `x`. This mirrors the Mealy detector timing.

## Configuration
- `SEQGEN_EXPECT_EN` defined: golden model compiled in.
  - Two-bit history h1, h2 of previous valid bits, plus a history count 0..2.
  - `exp_y` = `x_valid` & (count=2) & (`x`==h1==h2).
  - History shifts on every valid bit, continues across repeat wrap (overlapping), and clears in IDLE and on reset.
  - `hit_cnt` increments on each `exp_y`, saturates at 255, and clears on accepted `start`.
- Not defined: `exp_y` and `hit_cnt` ports are tied to 0, and no history logic is built.

## Structure
- Shared package `seqgen_pkg`: state enum (IDLE, SEND, DONE), default `W`, `hit_cnt` width constant.
- Sub-module `seq_run_tracker`: history and count, `exp_y`, `hit_cnt`. Instantiated only under `SEQGEN_EXPECT_EN`.

## Test plan
- `len`=16, `pattern`=16'b1000_1011_1011_1100, `repeat_en`=0 -> x stream 1,0,0,0,1,0,1,1,1,0,1,1,1,1,0,0; `exp_y` high on bits 4, 9, 13, 14 (1-based); `hit_cnt`=4; `done` one cycle after bit 16.
- `len`=3, `pattern`=3'b111, `repeat_en`=1 for two passes then 0 -> six consecutive 1s with no gap; `exp_y` high on bits 3–6; `hit_cnt`=4; `done` after bit 6.
- `stop` asserted during bit 5 of a 16-bit pass -> `x_valid`=0 and `done`=1 next cycle; IDLE after; total 5 valid bits.
- `start` pulsed while busy, and `start` with `len`=0 in IDLE -> no effect: stream unchanged, no `done`, no `busy`.
- `rst` driven low mid-SEND between edges -> `x`, `x_valid`, `busy`, `done`, `exp_y`, `hit_cnt` go 0 immediately; after release, next `start` behaves normally.
- `len`=20 with W=16 -> exactly 16 bits sent from `pattern[15]` down to `pattern[0]`.
